// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
// Handshaked data-memory port used by the load/store unit.
//   mem_req    : request valid (LSU -> memory)
//   mem_we     : write enable (LSU -> memory)
//   mem_addr   : word-aligned byte address (LSU -> memory)
//   mem_be     : byte-lane enables (LSU -> memory)
//   mem_wdata  : lane-replicated store data (LSU -> memory)
//   mem_gnt    : request accepted this cycle (memory -> LSU)
//   mem_rvalid : read data valid (memory -> LSU)
//   mem_rdata  : read data word (memory -> LSU)
// master = LSU side, slave = memory side.
// -----------------------------------------------------------------------------
interface lsu_mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit sitting between the ALU result and a handshaked data memory.
// Accepts one load or store per request, checks funct3 legality and alignment,
// issues a byte-lane-masked word access and formats load data with sign/zero
// extension. The datapath is stalled until the access completes.
//
// Parameters:
//   TIMEOUT     : max cycles spent waiting for mem_rvalid before abort (1..65535)
// Ports:
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   req_valid   : current instruction is a load/store
//   req_store   : 1 = store, 0 = load
//   req_funct3  : RISC-V funct3 (width / sign)
//   req_addr    : effective byte address
//   req_wdata   : store data (rs2)
//   stall       : hold PC and write-back
//   load_valid  : one-cycle pulse, load_data valid
//   load_data   : extended load result (held until the next load)
//   misaligned  : one-cycle pulse, access aborted without a memory transaction
//   bus_timeout : one-cycle pulse, load aborted after TIMEOUT wait cycles
//   mem         : memory port (master side)
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_store,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   stall,
    output logic                   load_valid,
    output logic [31:0]            load_data,
    output logic                   misaligned,
    output logic                   bus_timeout,
    lsu_mem_stage_if.master        mem
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_timeout_q, bus_timeout_d;

    // -------------------------------------------------------------------------
    // Request qualification (only evaluated against the live req_* in IDLE)
    // -------------------------------------------------------------------------
    logic req_legal;
    logic req_aligned;

    always_comb begin
        req_legal = 1'b0;
        if (req_store) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
        end else begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                        (req_funct3 == 3'b101);
        end
    end

    always_comb begin
        req_aligned = 1'b1;
        case (req_funct3[1:0])
            2'b01:   req_aligned = (req_addr[0] == 1'b0);
            2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Lane mask and store data from the latched request
    // -------------------------------------------------------------------------
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
    end

    // Memory outputs are only driven while a request is outstanding so the
    // bus sits at zero in every other state, including right after reset.
    logic in_req;
    assign in_req        = (state_q == S_REQ);
    assign mem.mem_req   = in_req;
    assign mem.mem_we    = in_req & store_q;
    assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_be    = in_req ? lane_be : 4'd0;
    assign mem.mem_wdata = in_req ? lane_wdata : 32'd0;

    // -------------------------------------------------------------------------
    // Load data formatting
    // -------------------------------------------------------------------------
    logic [7:0]  rdata_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] fmt_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign rdata_byte[gi] = mem.mem_rdata[8*gi +: 8];
    end

    always_comb begin
        sel_byte = rdata_byte[addr_q[1:0]];
        sel_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        fmt_data = mem.mem_rdata;
        case (funct3_q)
            3'b000:  fmt_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  fmt_data = {24'd0, sel_byte};
            3'b001:  fmt_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  fmt_data = {16'd0, sel_half};
            default: fmt_data = mem.mem_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        store_d       = store_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        load_data_d   = load_data_q;
        load_valid_d  = 1'b0;
        misaligned_d  = 1'b0;
        bus_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    // Illegal funct3 is reported through the misaligned pulse.
                    if (req_legal && req_aligned) begin
                        state_d = S_REQ;
                    end else begin
                        state_d      = S_ERR;
                        misaligned_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    cnt_d = 16'd0;
                    if (store_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // rvalid wins on the final allowed cycle.
                if (mem.mem_rvalid) begin
                    load_data_d  = fmt_data;
                    load_valid_d = 1'b1;
                    cnt_d        = 16'd0;
                    state_d      = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_timeout_d = 1'b1;
                    cnt_d         = 16'd0;
                    state_d       = S_ERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            store_q       <= 1'b0;
            funct3_q      <= 3'd0;
            addr_q        <= 32'd0;
            wdata_q       <= 32'd0;
            cnt_q         <= 16'd0;
            load_data_q   <= 32'd0;
            load_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            load_data_q   <= load_data_d;
            load_valid_q  <= load_valid_d;
            misaligned_q  <= misaligned_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // The completion cycles (DONE/ERR) release the stall so the core advances
    // in the same cycle the result pulses appear.
    assign stall       = req_valid && (state_q != S_DONE) && (state_q != S_ERR);
    assign load_valid  = load_valid_q;
    assign load_data   = load_data_q;
    assign misaligned  = misaligned_q;
    assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage (TIMEOUT=4). Inputs change on the falling
// edge, outputs are sampled 1 ns later; the memory side reacts to mem_req.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misaligned;
    logic        bus_timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_mem_stage_if mif ();

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_store   (req_store),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stall       (stall),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .bus_timeout (bus_timeout),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one request to completion (stall released) and checks the result.
    task automatic run_txn(
        input string       name,
        input logic        st,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] wd,
        input int          gnt_dly,
        input int          rv_dly,
        input logic [31:0] rd,
        input logic        spur,
        input int          e_stall,
        input int          e_lv,
        input int          e_mis,
        input int          e_to,
        input logic [31:0] e_addr,
        input logic [3:0]  e_be,
        input logic [31:0] e_wd,
        input logic [31:0] e_ld
    );
        int          stall_cyc = 0;
        int          lv = 0;
        int          mis = 0;
        int          tmo = 0;
        int          req_cyc = 0;
        int          wcnt = 0;
        int          c = 0;
        logic        granted = 1'b0;
        logic        done = 1'b0;
        logic [31:0] cap_addr = 32'd0;
        logic [31:0] cap_wd = 32'd0;
        logic [3:0]  cap_be = 4'd0;
        logic        cap_we = 1'b0;
        logic [31:0] ld = 32'd0;

        while (!done && c < 40) begin
            @(negedge clk);
            req_valid      = 1'b1;
            req_store      = st;
            req_funct3     = f3;
            req_addr       = a;
            req_wdata      = wd;
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = 32'h5555_5555;
            if (granted && !st) begin
                if (wcnt == rv_dly) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = rd;
                end
                wcnt++;
            end
            #1;
            if (c == 0) begin
                check({name, "_idle_lv"},  32'(load_valid),  32'd0);
                check({name, "_idle_mis"}, 32'(misaligned),  32'd0);
                check({name, "_idle_to"},  32'(bus_timeout), 32'd0);
            end
            if (mif.mem_req) begin
                if (req_cyc == gnt_dly) begin
                    mif.mem_gnt = 1'b1;
                    cap_addr    = mif.mem_addr;
                    cap_be      = mif.mem_be;
                    cap_we      = mif.mem_we;
                    cap_wd      = mif.mem_wdata;
                    granted     = 1'b1;
                end else if (spur) begin
                    mif.mem_rvalid = 1'b1;
                end
                req_cyc++;
            end
            if (stall)       stall_cyc++;
            if (load_valid)  lv++;
            if (misaligned)  mis++;
            if (bus_timeout) tmo++;
            if (!stall) begin
                done = 1'b1;
                ld   = load_data;
            end
            c++;
        end
        req_valid      = 1'b0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;

        $display("txn %s: stall=%0d lv=%0d mis=%0d to=%0d req=%0d addr=%h be=%b we=%b wd=%h ld=%h",
                 name, stall_cyc, lv, mis, tmo, req_cyc, cap_addr, cap_be, cap_we, cap_wd, ld);

        check({name, "_done"},  32'(done),      32'd1);
        check({name, "_stall"}, 32'(stall_cyc), 32'(e_stall));
        check({name, "_lv"},    32'(lv),        32'(e_lv));
        check({name, "_mis"},   32'(mis),       32'(e_mis));
        check({name, "_to"},    32'(tmo),       32'(e_to));
        check({name, "_ld"},    ld,             e_ld);
        check({name, "_reqcyc"}, 32'(req_cyc),  (e_mis != 0) ? 32'd0 : 32'(gnt_dly + 1));
        if (e_mis == 0) begin
            check({name, "_addr"}, cap_addr,     e_addr);
            check({name, "_be"},   32'(cap_be),  32'(e_be));
            check({name, "_we"},   32'(cap_we),  32'(st));
            if (st) begin
                check({name, "_wdata"}, cap_wd, e_wd);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_store      = 1'b0;
        req_funct3     = 3'd0;
        req_addr       = 32'd0;
        req_wdata      = 32'd0;
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 32'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall",     32'(stall),          32'd0);
        check("rst_lv",        32'(load_valid),     32'd0);
        check("rst_ld",        load_data,           32'd0);
        check("rst_mis",       32'(misaligned),     32'd0);
        check("rst_to",        32'(bus_timeout),    32'd0);
        check("rst_req",       32'(mif.mem_req),    32'd0);
        check("rst_we",        32'(mif.mem_we),     32'd0);
        check("rst_addr",      mif.mem_addr,        32'd0);
        check("rst_be",        32'(mif.mem_be),     32'd0);
        check("rst_wdata",     mif.mem_wdata,       32'd0);
        @(negedge clk);
        req_valid = 1'b1;
        #1;
        check("rst_stall_follows", 32'(stall), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b0;

        //        name     st    f3      addr          wdata         gnt rv rdata         spur stl lv mis to  e_addr        be       e_wd          e_ld
        run_txn("sw",     1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0,        1'b0, 2, 0, 0, 0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        run_txn("sb",     1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 0, 0, 32'h0,        1'b0, 2, 0, 0, 0, 32'h0000_0200, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        run_txn("lb",     1'b0, 3'b000, 32'h0000_0302, 32'h0,         0, 0, 32'h12F0_3456, 1'b0, 3, 1, 0, 0, 32'h0000_0300, 4'b0100, 32'h0,         32'hFFFF_FFF0);
        run_txn("lbu",    1'b0, 3'b100, 32'h0000_0302, 32'h0,         0, 0, 32'h12F0_3456, 1'b0, 3, 1, 0, 0, 32'h0000_0300, 4'b0100, 32'h0,         32'h0000_00F0);
        run_txn("lh_mis", 1'b0, 3'b001, 32'h0000_0401, 32'h0,         0, 0, 32'h0,        1'b0, 1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0000_00F0);
        run_txn("lw_slow", 1'b0, 3'b010, 32'h0000_0500, 32'h0,        3, 2, 32'h89AB_CDEF, 1'b1, 8, 1, 0, 0, 32'h0000_0500, 4'b1111, 32'h0,         32'h89AB_CDEF);
        run_txn("lhu",    1'b0, 3'b101, 32'h0000_0602, 32'h0,         1, 1, 32'h8001_7FFF, 1'b0, 5, 1, 0, 0, 32'h0000_0600, 4'b1100, 32'h0,         32'h0000_8001);
        run_txn("lh",     1'b0, 3'b001, 32'h0000_0602, 32'h0,         0, 0, 32'h8001_7FFF, 1'b0, 3, 1, 0, 0, 32'h0000_0600, 4'b1100, 32'h0,         32'hFFFF_8001);
        run_txn("lw_tmo", 1'b0, 3'b010, 32'h0000_0700, 32'h0,         0, 100, 32'h0,      1'b0, 6, 0, 0, 1, 32'h0000_0700, 4'b1111, 32'h0,         32'hFFFF_8001);
        run_txn("s_ill",  1'b1, 3'b100, 32'h0000_0800, 32'h1111_2222, 0, 0, 32'h0,        1'b0, 1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'hFFFF_8001);
        run_txn("sh",     1'b1, 3'b001, 32'h0000_0802, 32'h1234_ABCD, 0, 0, 32'h0,        1'b0, 2, 0, 0, 0, 32'h0000_0800, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_8001);

        // Reset while waiting for read data, then a late rvalid.
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0900;
        #1;
        @(negedge clk);
        #1;
        check("mrst_req", 32'(mif.mem_req), 32'd1);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        mif.mem_gnt = 1'b0;
        reset       = 1'b1;
        #1;
        check("mrst_wait_stall", 32'(stall), 32'd1);
        @(negedge clk);
        reset          = 1'b0;
        req_valid      = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata  = 32'hCAFE_F00D;
        #1;
        check("mrst_lv",    32'(load_valid),  32'd0);
        check("mrst_ld",    load_data,        32'd0);
        check("mrst_req0",  32'(mif.mem_req), 32'd0);
        check("mrst_addr",  mif.mem_addr,     32'd0);
        check("mrst_be",    32'(mif.mem_be),  32'd0);
        check("mrst_stall", 32'(stall),       32'd0);
        @(negedge clk);
        mif.mem_rvalid = 1'b0;
        #1;
        check("mrst_lv2",   32'(load_valid),  32'd0);
        check("mrst_ld2",   load_data,        32'd0);
        check("mrst_to2",   32'(bus_timeout), 32'd0);
        $display("txn reset_in_wait: lv=%b ld=%h req=%b", load_valid, load_data, mif.mem_req);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit between the core datapath's ALU result and a handshaked data memory port. It takes one load or store per request, checks alignment and checks funct3 for legality. It drives byte-lane-masked word accesses. Loads get byte/half/word extraction with sign or zero extension. The unit stalls the datapath until the access completes, so the core keeps single-cycle semantics with a variable-latency memory.

## Interface
- TIMEOUT, default 255: max cycles in WAIT for mem_rvalid before abort; 1..65535.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  current instruction is a load/store.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (width/sign).
- req_addr  in  32  effective address (ALU result).
- req_wdata  in  32  store data (rs2 value).
- stall  out  1  hold PC and register write-back.
- load_valid  out  1  one-cycle pulse; load_data valid.
- load_data  out  32  extended load result.
- misaligned  out  1  one-cycle pulse; access aborted, no memory transaction.
- bus_timeout  out  1  one-cycle pulse; load aborted after TIMEOUT.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, {req_addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE, req_valid=0: stay in IDLE.
- IDLE, req_valid=1: latch store, funct3, addr, wdata.
  - Legal and aligned: go to REQ.
  - Otherwise: go to ERR.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001, 010.
  - Any other value is handled as misaligned.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00.
- REQ: mem_req=1, with mem_we/mem_addr/mem_be/mem_wdata held stable until mem_gnt.
  - On mem_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: a counter starts at 0 and increments each cycle.
  - mem_rvalid: capture the formatted data and go to DONE.
  - Counter reaches TIMEOUT-1 without mem_rvalid: go to ERR, which pulses bus_timeout.
- DONE: stall=0; load_valid=1 if load; go to IDLE.
- ERR: stall=0; pulse misaligned or bus_timeout (exactly one); go to IDLE.
- stall = req_valid and state not in {DONE, ERR}.
- Store lanes, with o = addr[1:0]:
  - SB: mem_be = 1<<o, mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_be = 0011 (o=0) or 1100 (o=2), mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_be = 1111, mem_wdata = wdata.
- Load lanes: mem_be uses the same masks; mem_we=0.
  - Select byte o or half o[1] of mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- mem_rvalid outside WAIT is ignored.
- mem_gnt outside REQ is ignored.
- req_* inputs are not sampled outside IDLE; the latched copy is used.
- The datapath may gate register write-back on load_valid.
- Store commits when mem_gnt is asserted in REQ.

## Timing
- Reset (sync, active-high): state=IDLE, counter=0.
  - All outputs 0: load_data=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - stall is combinational and still follows req_valid in IDLE.
- Reset mid-transaction: abort to IDLE; no load_valid; a later mem_rvalid is ignored.
- Store, gnt immediate: 3 cycles (IDLE, REQ, DONE); stall high 2 cycles.
- Load, gnt immediate, rvalid 1 cycle later: 4 cycles (IDLE, REQ, WAIT, DONE); stall high 3 cycles.
- Misaligned: 2 cycles (IDLE, ERR); stall high 1 cycle; mem_req never asserted.
- load_data and load_valid are registered and valid in the DONE cycle only.
  - load_data holds its value afterwards until the next load.
- Back-to-back: a new request is accepted in the IDLE cycle immediately following DONE or ERR.
- Each gnt wait cycle in REQ and each rvalid wait cycle in WAIT adds one stall cycle.

## Test plan
- SW addr 0x104, wdata 0xDEADBEEF, gnt on 1st REQ cycle:
  - mem_addr 0x104, be 1111, we=1, wdata 0xDEADBEEF; stall high exactly 2 cycles.
- SB addr 0x203, wdata 0x000000A5:
  - mem_addr 0x200, be 1000, mem_wdata 0xA5A5A5A5.
- LB and LBU at addr 0x302, mem_rdata 0x12F0_3456:
  - LB gives load_data 0xFFFFFFF0; LBU gives 0x000000F0.
  - load_valid pulses 1 cycle each.
- LH addr 0x401:
  - misaligned pulses once, mem_req stays 0, stall high 1 cycle.
  - Next request is accepted the following cycle.
- LW with mem_gnt delayed 3 cycles and rvalid delayed 2:
  - stall high 3+2+3=8 cycles; load_data = mem_rdata.
  - Spurious mem_rvalid during REQ is ignored.
- TIMEOUT=4, LW, no rvalid:
  - bus_timeout pulses after 4 WAIT cycles, no load_valid.
- Separate run: reset asserted in WAIT, then rvalid:
  - state IDLE, outputs 0, rvalid ignored.
